// File: rtl/wl_pkg.sv
// Shared helpers and tag type for the wl shared-multiplier controllers.
// Tag ids are sized for the largest supported requester count; users compare only the low bits they need.
package wl_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int NREQ_MAX = 8;
  localparam int IDW_MAX  = clog2(NREQ_MAX);

  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/wl_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first eligible requester at or after ptr.
// Zero latency; no grant when nothing is eligible. ptr must be below NREQ.
module wl_rr_arb
  import wl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_vld
);

  logic [IDW:0] cand;

  // One extra bit on cand so ptr+k cannot overflow before the modulo wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_vld && elig[cand[IDW-1:0]]) begin
        gnt_vld            = 1'b1;
        gnt_idx            = cand[IDW-1:0];
        gnt[cand[IDW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wl_mult_arb.sv
// Shares one LAT-cycle multiplier between NREQ requesters; request-to-response latency LAT+1.
// Issue is throttled by per-requester credits (MAXOUT in flight); responses have no backpressure.
module wl_mult_arb
  import wl_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int IW     = 8,
  parameter int OW     = 8,
  parameter int LAT    = 4,
  parameter int MAXOUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*2*IW-1:0] req_din,
  output logic [NREQ-1:0]      req_ready,
  output logic [2*IW-1:0]      mul_din,
  input  logic [OW-1:0]        mul_dout,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [OW-1:0]        rsp_dout,
  output logic                 busy
);

  localparam int IDW = clog2(NREQ);
  localparam int CW  = clog2(MAXOUT + 1);

  tag_t               tag_q [LAT];
  logic [IDW-1:0]     ptr_q;
  logic [CW-1:0]      credit_q [NREQ];
  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_vld;
  logic               ret_vld;
  logic [IDW_MAX-1:0] ret_id;
  logic [NREQ-1:0]    ret_hot;

  // Gating with rst keeps the combinational outputs quiet while reset is held.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (credit_q[i] < CW'(MAXOUT)) && !rst;
    end
  end

  wl_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .elig    (elig),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign req_ready = gnt;

  always_comb begin
    mul_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) mul_din = req_din[i*2*IW +: 2*IW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{valid: gnt_vld, id: IDW_MAX'(gnt_idx)};
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign ret_vld = tag_q[LAT-1].valid;
  assign ret_id  = tag_q[LAT-1].id;

  always_comb begin
    ret_hot = '0;
    busy    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ret_hot[i] = ret_vld && (ret_id == IDW_MAX'(i));
    end
    for (int s = 0; s < LAT; s++) begin
      busy = busy | tag_q[s].valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_dout  <= '0;
    end else begin
      rsp_valid <= ret_hot;
      if (ret_vld) rsp_dout <= mul_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // A credit is returned the edge the tag leaves the pipeline, so it is reusable in the response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) credit_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && !ret_hot[i]) begin
          credit_q[i] <= credit_q[i] + CW'(1);
        end else if (!gnt[i] && ret_hot[i] && (credit_q[i] != '0)) begin
          credit_q[i] <= credit_q[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wl_mult_arb.sv
// Bench for wl_mult_arb: a 4-requester and a 3-requester instance share one requester stimulus.
// Expected traffic comes from a per-cycle grant history: an op holds its credit for LAT cycles after issue.
module tb_wl_mult_arb;

  localparam int IW     = 8;
  localparam int OW     = 8;
  localparam int LAT    = 4;
  localparam int MAXOUT = 2;
  localparam int MAXC   = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]        drv_valid;
  logic [2*IW-1:0]   drv_opnd [8];
  logic [4*2*IW-1:0] din4;
  logic [3*2*IW-1:0] din3;

  always_comb begin
    for (int i = 0; i < 4; i++) din4[i*2*IW +: 2*IW] = drv_opnd[i];
    for (int i = 0; i < 3; i++) din3[i*2*IW +: 2*IW] = drv_opnd[i];
  end

  logic [3:0]      rdy4, rv4;
  logic [2:0]      rdy3, rv3;
  logic [2*IW-1:0] md4, md3;
  logic [OW-1:0]   mo4, mo3, rd4, rd3;
  logic            busy4, busy3;

  wl_mult_arb #(.NREQ(4), .IW(IW), .OW(OW), .LAT(LAT), .MAXOUT(MAXOUT)) dut4 (
    .clk(clk), .rst(rst), .req_valid(drv_valid[3:0]), .req_din(din4), .req_ready(rdy4),
    .mul_din(md4), .mul_dout(mo4), .rsp_valid(rv4), .rsp_dout(rd4), .busy(busy4));

  wl_mult_arb #(.NREQ(3), .IW(IW), .OW(OW), .LAT(LAT), .MAXOUT(MAXOUT)) dut3 (
    .clk(clk), .rst(rst), .req_valid(drv_valid[2:0]), .req_din(din3), .req_ready(rdy3),
    .mul_din(md3), .mul_dout(mo3), .rsp_valid(rv3), .rsp_dout(rd3), .busy(busy3));

  // Multiplier stand-ins: LAT register stages, returning the upper OW bits of the full product.
  logic [2*IW-1:0] mp4 [LAT];
  logic [2*IW-1:0] mp3 [LAT];
  always @(posedge clk) begin
    mp4[0] <= (2*IW)'(md4[IW-1:0]) * (2*IW)'(md4[2*IW-1:IW]);
    mp3[0] <= (2*IW)'(md3[IW-1:0]) * (2*IW)'(md3[2*IW-1:IW]);
    for (int s = 1; s < LAT; s++) begin
      mp4[s] <= mp4[s-1];
      mp3[s] <= mp3[s-1];
    end
  end
  assign mo4 = mp4[LAT-1][2*IW-1 -: OW];
  assign mo3 = mp3[LAT-1][2*IW-1 -: OW];

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc;
  int            m_ptr;
  int            g_id [MAXC];
  logic [OW-1:0] g_prod [MAXC];
  logic [OW-1:0] m_last;
  logic [7:0]    pend;

  task automatic model_reset();
    cyc    = 0;
    m_ptr  = 0;
    m_last = '0;
    for (int t = 0; t < MAXC; t++) begin
      g_id[t]   = -1;
      g_prod[t] = '0;
    end
  endtask

  // Operations issued to id within the last LAT cycles still hold a credit.
  function automatic int outstanding(input int id);
    int cnt;
    cnt = 0;
    for (int t = cyc - LAT; t < cyc; t++) begin
      if (t >= 0 && g_id[t] == id) cnt++;
    end
    return cnt;
  endfunction

  task automatic sample(input int n, output logic [7:0] o_rdy, output logic [7:0] o_rv,
                        output logic [2*IW-1:0] o_md, output logic [OW-1:0] o_rd, output logic o_busy);
    if (n == 4) begin
      o_rdy = {4'b0, rdy4}; o_rv = {4'b0, rv4}; o_md = md4; o_rd = rd4; o_busy = busy4;
    end else begin
      o_rdy = {5'b0, rdy3}; o_rv = {5'b0, rv3}; o_md = md3; o_rd = rd3; o_busy = busy3;
    end
  endtask

  task automatic apply_reset(input int n, input string name);
    logic [7:0] o_rdy, o_rv;
    logic [2*IW-1:0] o_md;
    logic [OW-1:0] o_rd;
    logic o_busy;
    rst = 1'b1;
    #1;
    sample(n, o_rdy, o_rv, o_md, o_rd, o_busy);
    n_vec += 5;
    if (o_rdy !== 8'h00) begin n_err++; $display("FAIL %s req_ready got %b want 0", name, o_rdy); end
    if (o_rv !== 8'h00) begin n_err++; $display("FAIL %s rsp_valid got %b want 0", name, o_rv); end
    if (o_md !== '0) begin n_err++; $display("FAIL %s mul_din got %h want 0", name, o_md); end
    if (o_rd !== '0) begin n_err++; $display("FAIL %s rsp_dout got %h want 0", name, o_rd); end
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL %s busy got %b want 0", name, o_busy); end
    pend      = '0;
    drv_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_cycle(input int n, input logic [7:0] new_req, input string name);
    int exp_g, idx, t;
    logic [7:0] exp_rdy, exp_rv, o_rdy, o_rv;
    logic [2*IW-1:0] exp_md, o_md, p;
    logic [OW-1:0] exp_rd, o_rd;
    logic exp_busy, o_busy;
    for (int i = 0; i < n; i++) begin
      if (!pend[i] && new_req[i]) begin
        pend[i]     = 1'b1;
        drv_opnd[i] = (2*IW)'($urandom);
      end
    end
    drv_valid = pend;
    exp_g = -1;
    for (int k = 0; k < n; k++) begin
      idx = (m_ptr + k) % n;
      if (exp_g < 0 && pend[idx] && outstanding(idx) < MAXOUT) exp_g = idx;
    end
    exp_rdy = '0;
    exp_md  = '0;
    if (exp_g >= 0) begin
      exp_rdy[exp_g] = 1'b1;
      exp_md         = drv_opnd[exp_g];
    end
    t      = cyc - LAT - 1;
    exp_rv = '0;
    exp_rd = m_last;
    if (t >= 0 && g_id[t] >= 0) begin
      exp_rv[g_id[t]] = 1'b1;
      exp_rd          = g_prod[t];
    end
    m_last   = exp_rd;
    exp_busy = 1'b0;
    for (int s = cyc - LAT; s < cyc; s++) begin
      if (s >= 0 && g_id[s] >= 0) exp_busy = 1'b1;
    end
    @(negedge clk);
    sample(n, o_rdy, o_rv, o_md, o_rd, o_busy);
    n_vec += 5;
    if (o_rdy !== exp_rdy) begin n_err++; $display("FAIL %s cyc %0d req_ready got %b want %b", name, cyc, o_rdy, exp_rdy); end
    if (o_md !== exp_md) begin n_err++; $display("FAIL %s cyc %0d mul_din got %h want %h", name, cyc, o_md, exp_md); end
    if (o_rv !== exp_rv) begin n_err++; $display("FAIL %s cyc %0d rsp_valid got %b want %b", name, cyc, o_rv, exp_rv); end
    if (o_rd !== exp_rd) begin n_err++; $display("FAIL %s cyc %0d rsp_dout got %h want %h", name, cyc, o_rd, exp_rd); end
    if (o_busy !== exp_busy) begin n_err++; $display("FAIL %s cyc %0d busy got %b want %b", name, cyc, o_busy, exp_busy); end
    if (cyc < MAXC) begin
      g_id[cyc] = exp_g;
      if (exp_g >= 0) begin
        p = (2*IW)'(drv_opnd[exp_g][IW-1:0]) * (2*IW)'(drv_opnd[exp_g][2*IW-1:IW]);
        g_prod[cyc] = p[2*IW-1 -: OW];
        pend[exp_g] = 1'b0;
        m_ptr       = (exp_g + 1) % n;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    drv_valid = pend;
  endtask

  task automatic test_reset();
    drv_valid = 8'hFF;
    for (int i = 0; i < 8; i++) drv_opnd[i] = (2*IW)'($urandom);
    apply_reset(4, "reset4");
    drv_valid = 8'hFF;
    apply_reset(3, "reset3");
    for (int c = 0; c < 3; c++) run_cycle(4, 8'h00, "idle");
  endtask

  task automatic test_single();
    apply_reset(4, "single_rst");
    pend[0] = 1'b1;
    drv_opnd[0] = {8'd10, 8'd12};
    for (int c = 0; c < 8; c++) run_cycle(4, 8'h00, "single_a");
    pend[0] = 1'b1;
    drv_opnd[0] = {8'd150, 8'd200};
    for (int c = 0; c < 8; c++) run_cycle(4, 8'h00, "single_b");
  endtask

  task automatic test_back_to_back();
    apply_reset(4, "rr_rst");
    for (int c = 0; c < 40; c++) run_cycle(4, 8'h0F, "round_robin");
  endtask

  task automatic test_credit_limit();
    apply_reset(4, "credit_rst");
    for (int c = 0; c < 20; c++) run_cycle(4, 8'h04, "credit_limit");
  endtask

  task automatic test_same_cycle();
    apply_reset(4, "same_rst");
    run_cycle(4, 8'h02, "same_cycle");
    for (int c = 0; c < 3; c++) run_cycle(4, 8'h00, "same_cycle");
    for (int c = 0; c < 12; c++) run_cycle(4, 8'h02, "same_cycle");
  endtask

  task automatic test_random();
    apply_reset(4, "rand_rst");
    for (int c = 0; c < 300; c++) run_cycle(4, 8'($urandom), "random4");
  endtask

  task automatic test_reset_mid();
    apply_reset(4, "mid_pre");
    for (int c = 0; c < 3; c++) run_cycle(4, 8'h0F, "mid_load");
    apply_reset(4, "reset_mid");
    for (int c = 0; c < LAT + 2; c++) run_cycle(4, 8'h00, "mid_quiet");
    for (int c = 0; c < 10; c++) run_cycle(4, 8'b1010, "mid_after");
  endtask

  task automatic test_nreq3();
    apply_reset(3, "n3_rst");
    for (int c = 0; c < 30; c++) run_cycle(3, 8'b101, "n3_alt");
    for (int c = 0; c < 150; c++) run_cycle(3, 8'($urandom), "n3_random");
  endtask

  initial begin
    rst       = 1'b1;
    drv_valid = '0;
    pend      = '0;
    for (int i = 0; i < 8; i++) drv_opnd[i] = '0;
    for (int s = 0; s < LAT; s++) begin
      mp4[s] = '0;
      mp3[s] = '0;
    end
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_credit_limit();
    test_same_cycle();
    test_random();
    test_reset_mid();
    test_nreq3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
